// File: rtl/scan_pkg.sv
// scan_pkg: shared state encoding, default MISR taps and parity helper for scan_unload.
package scan_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam logic [7:0] DEF_POLY = 8'h1D;
  function automatic logic parity(input logic [63:0] v);
    return ^v;
  endfunction
endpackage

// File: rtl/scan_misr.sv
// scan_misr: response signature register, built only when SCAN_UNLOAD_MISR_EN is defined.
`ifdef SCAN_UNLOAD_MISR_EN
module scan_misr import scan_pkg::*; #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY = WIDTH'(DEF_POLY)
) (
  input  logic             clock,
  input  logic             reset_l,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sig
);
  // clear wins over the old signature, so a same-cycle capture folds into zero
  always_ff @(posedge clock)
    if (!reset_l) sig <= '0;
    else if (clear) sig <= en ? din : '0;
    else if (en) sig <= {sig[WIDTH-2:0], parity(64'(sig & POLY))} ^ din;
endmodule
`endif

// File: rtl/scan_unload.sv
// scan_unload: captures a response vector and shifts it out LSB-first on a valid/ready channel.
// Define SCAN_UNLOAD_MISR_EN to fold every captured vector into the sig MISR; otherwise sig is 0.
module scan_unload import scan_pkg::*; #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY = WIDTH'(DEF_POLY)
) (
  input  logic             clock,
  input  logic             reset_l,
  input  logic             cap_valid,
  input  logic [WIDTH-1:0] cap_data,
  output logic             cap_ready,
  output logic             so_valid,
  output logic             so_data,
  output logic             so_last,
  input  logic             so_ready,
  input  logic             sig_clear,
  output logic [WIDTH-1:0] sig
);
  localparam int CW = $clog2(WIDTH);
  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             cap_fire;
  assign cap_fire = cap_valid && cap_ready;
  assign so_data  = shreg[0];
  // so_last is registered one beat early so it lines up with counter == WIDTH-1
  always_ff @(posedge clock)
    if (!reset_l) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      cap_ready <= 1'b0;
      so_valid  <= 1'b0;
      so_last   <= 1'b0;
    end else if (state == IDLE) begin
      cap_ready <= !cap_fire;
      if (cap_fire) begin
        state    <= SHIFT;
        shreg    <= cap_data;
        cnt      <= '0;
        so_valid <= 1'b1;
        so_last  <= 1'b0;
      end
    end else if (so_ready) begin
      shreg <= shreg >> 1;
      if (so_last) begin
        state     <= IDLE;
        so_valid  <= 1'b0;
        so_last   <= 1'b0;
        cap_ready <= 1'b1;
      end else begin
        cnt     <= cnt + CW'(1);
        so_last <= cnt == CW'(WIDTH - 2);
      end
    end
`ifdef SCAN_UNLOAD_MISR_EN
  scan_misr #(.WIDTH(WIDTH), .POLY(POLY)) u_misr (
    .clock   (clock),
    .reset_l (reset_l),
    .en      (cap_fire),
    .clear   (sig_clear),
    .din     (cap_data),
    .sig     (sig)
  );
`else
  logic unused_sig_clear;
  assign unused_sig_clear = sig_clear;
  assign sig = '0;
`endif
endmodule
